// File: rtl/rs232_tx_fifo.sv
// rs232_tx_fifo: byte FIFO plus launch sequencer feeding the RS232 transmitter.
// Optional macro RS232_TX_CTS_EN adds a cts input (2-flop synchronised) that gates launches.
module rs232_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic [7:0]            wdata,
  input  logic                  clr_ovf,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  ovf,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  input  logic                  tx_rdy
`ifdef RS232_TX_CTS_EN
  ,
  input  logic                  cts
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_GUARD = 2'd2;
  localparam logic [1:0] ST_BUSY  = 2'd3;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  ovf_q, ovf_d;
  logic [1:0]            state_q, state_d;
  logic                  tx_start_q, tx_start_d;
  logic [7:0]            tx_data_q;
  logic                  launch_ok;
  logic                  push;
  logic                  pop;

`ifdef RS232_TX_CTS_EN
  logic cts_meta_q;
  logic cts_sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cts_meta_q <= 1'b0;
      cts_sync_q <= 1'b0;
    end else begin
      cts_meta_q <= cts;
      cts_sync_q <= cts_meta_q;
    end
  end

  assign launch_ok = cts_sync_q;
`else
  assign launch_ok = 1'b1;
`endif

  // full_q is the pre-edge flag, so a write while full is dropped even if a pop lands this cycle.
  assign push = wr & ~full_q;
  assign pop  = (state_q == ST_IDLE) & ~empty_q & tx_rdy & launch_ok;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CNT_FULL);
    empty_d = (count_d == '0);
    if (wr & full_q) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  // GUARD ignores tx_rdy for one cycle because the transmitter drops rdy a cycle after start.
  always_comb begin
    state_d    = state_q;
    tx_start_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          tx_start_d = 1'b1;
          state_d    = ST_LOAD;
        end
      end
      ST_LOAD:  state_d = ST_GUARD;
      ST_GUARD: state_d = ST_BUSY;
      ST_BUSY: begin
        if (tx_rdy) begin
          state_d = ST_IDLE;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data_q <= 8'h00;
    end else if (pop) begin
      tx_data_q <= mem[rd_ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      ovf_q      <= 1'b0;
      state_q    <= ST_IDLE;
      tx_start_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      ovf_q      <= ovf_d;
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
    end
  end

  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;
  assign ovf      = ovf_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_rs232_tx_fifo.sv
// Self-checking bench for rs232_tx_fifo: directed phases plus randomized traffic,
// scored against a queue-based reference model and a simple transmitter model.
module tb_rs232_tx_fifo;

  localparam int DL2   = 4;
  localparam int DEPTH = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           wr = 1'b0;
  logic [7:0]     wdata = 8'h00;
  logic           clr_ovf = 1'b0;
  logic           tx_rdy = 1'b1;
  logic           full, empty, ovf, tx_start;
  logic [DL2:0]   count;
  logic [7:0]     tx_data;
`ifdef RS232_TX_CTS_EN
  logic           cts = 1'b1;
  bit             cts_hist [64];
`endif

  always #5 clk = ~clk;

  rs232_tx_fifo #(.DEPTH_LOG2(DL2)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr       (wr),
    .wdata    (wdata),
    .clr_ovf  (clr_ovf),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .ovf      (ovf),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_rdy   (tx_rdy)
`ifdef RS232_TX_CTS_EN
    ,
    .cts      (cts)
`endif
  );

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  // Reference model state: queued bytes, flags, and launch-timing bookkeeping by cycle index.
  logic [7:0] q_m [$];
  int         cnt_m = 0;
  bit         ovf_m = 1'b0;
  logic [7:0] data_m = 8'h00;
  int         last_rst = 0;
  int         last_start = -100;
  int         rdy_back = -10;
  bit         pending = 1'b0;
  int         busy_until = -1;
  int         ext_busy_pct = 0;
  int         frame_min = 3;
  int         frame_max = 6;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cyc=%0d observed=0x%0h expected=0x%0h", tag, cyc, obs, exp);
  endtask

  task automatic tick();
    bit         p_wr, p_clr, p_rst, p_rdy, exp_start, accept, cts_ok;
    logic [7:0] p_wdata;
    int         cnt_prev;
    p_wr    = wr;
    p_clr   = clr_ovf;
    p_rst   = rst;
    p_rdy   = tx_rdy;
    p_wdata = wdata;
    @(posedge clk);
    #1;
    cyc++;
`ifdef RS232_TX_CTS_EN
    cts_hist[(cyc - 1) % 64] = cts;
`endif
    exp_start = 1'b0;
    if (p_rst) begin
      q_m.delete();
      cnt_m      = 0;
      ovf_m      = 1'b0;
      data_m     = 8'h00;
      pending    = 1'b0;
      rdy_back   = -10;
      busy_until = -1;
      last_rst   = cyc - 1;
    end else begin
      cnt_prev = cnt_m;
`ifdef RS232_TX_CTS_EN
      // cts seen by the launch decision in cycle c-1 is the value driven in cycle c-3.
      cts_ok = (cyc - 3 >= last_rst + 1) && cts_hist[(cyc - 3) % 64];
`else
      cts_ok = 1'b1;
`endif
      exp_start = !pending && (cyc - 1 >= rdy_back + 1) && (cnt_prev > 0) && p_rdy && cts_ok;
      accept = p_wr && (cnt_prev < DEPTH);
      if (p_wr && !accept) ovf_m = 1'b1;
      else if (p_clr) ovf_m = 1'b0;
      if (exp_start) data_m = q_m.pop_front();
      if (accept) q_m.push_back(p_wdata);
      cnt_m = q_m.size();
    end

    chk("tx_start", {31'd0, tx_start}, {31'd0, exp_start});
    chk("tx_data", {24'd0, tx_data}, {24'd0, data_m});
    chk("count", {27'd0, count}, cnt_m);
    chk("full", {31'd0, full}, (cnt_m == DEPTH) ? 1 : 0);
    chk("empty", {31'd0, empty}, (cnt_m == 0) ? 1 : 0);
    chk("ovf", {31'd0, ovf}, {31'd0, ovf_m});
    if (exp_start) begin
      $display("cyc=%0d launch data=0x%02h queued=%0d", cyc, data_m, cnt_m);
    end

    if (exp_start) begin
      last_start = cyc;
      pending    = 1'b1;
      busy_until = cyc + $urandom_range(frame_max, frame_min);
    end
    tx_rdy = !(((cyc > last_start) && (cyc <= busy_until)) ||
               ($urandom_range(99, 0) < ext_busy_pct));
    if (pending && (cyc >= last_start + 2) && tx_rdy) begin
      rdy_back = cyc;
      pending  = 1'b0;
    end
    wr      = 1'b0;
    clr_ovf = 1'b0;
    rst     = 1'b0;
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    tick();

    // Single byte into empty FIFO: launched two cycles after the write
    wr = 1'b1; wdata = 8'h55;
    tick();
    repeat (12) tick();

    // Burst with a long frame: first byte launches, the remaining 16 fill the FIFO
    frame_min = 100; frame_max = 100;
    for (int i = 1; i <= 17; i++) begin
      wr = 1'b1; wdata = i[7:0];
      tick();
    end

    // Write while full is dropped; clr_ovf clears; simultaneous wr-full and clr keeps ovf set
    wr = 1'b1; wdata = 8'hAA;
    tick();
    tick();
    clr_ovf = 1'b1;
    tick();
    wr = 1'b1; wdata = 8'hBB; clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b1;
    tick();
    frame_min = 2; frame_max = 5;
    repeat (250) tick();

    // Randomized traffic: coincident push/pop, overflow, pointer wrap, external busy
    ext_busy_pct = 15;
    frame_min = 1; frame_max = 6;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99, 0) < ((i < 300) ? 60 : 20)) begin
        wr = 1'b1; wdata = 8'($urandom);
      end
      if ($urandom_range(99, 0) < 5) clr_ovf = 1'b1;
`ifdef RS232_TX_CTS_EN
      if ($urandom_range(99, 0) < 10) cts = ~cts;
`endif
      tick();
    end
    ext_busy_pct = 0;
`ifdef RS232_TX_CTS_EN
    cts = 1'b1;
`endif
    repeat (150) tick();

    // Reset while busy with bytes queued: everything dropped, no further launches
    frame_min = 30; frame_max = 30;
    for (int i = 0; i < 4; i++) begin
      wr = 1'b1; wdata = 8'hC0 + i[7:0];
      tick();
    end
    repeat (8) tick();
    rst = 1'b1;
    tick();
    repeat (30) tick();

`ifdef RS232_TX_CTS_EN
    // cts low blocks launches; raising it releases the queued byte
    frame_min = 3; frame_max = 3;
    cts = 1'b0;
    repeat (5) tick();
    wr = 1'b1; wdata = 8'h33;
    tick();
    repeat (50) tick();
    cts = 1'b1;
    repeat (10) tick();
`endif

    frame_min = 2; frame_max = 4;
    for (int i = 0; i < 3; i++) begin
      wr = 1'b1; wdata = 8'h7E - i[7:0];
      tick();
    end
    repeat (30) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
